// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// One transaction in flight: IDLE (arbitrate) -> EXEC (drive ALU) -> RESP (hold result).
module alu_share_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*OPW-1:0]  req_op,
    input  logic [2*XLEN-1:0] req_a,
    input  logic [2*XLEN-1:0] req_b,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [OPW-1:0]    alu_op,
    output logic [XLEN-1:0]   alu_rs1,
    output logic [XLEN-1:0]   alu_rs2,
    output logic [1:0]        alu_imme_sel,
    input  logic [XLEN-1:0]   alu_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [OPW-1:0] OP_LAST = OPW'(9);

    logic [1:0]      state_q, state_d;
    logic            rr_q, rr_d;
    logic            owner_q, owner_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            err_q, err_d;

    logic win_vld;
    logic win;
    logic op_bad;

    // Pointer holder has priority; otherwise the other side if it is asking.
    always_comb begin
        win_vld = 1'b0;
        win     = rr_q;
        if (req_valid[rr_q]) begin
            win_vld = 1'b1;
            win     = rr_q;
        end else if (req_valid[~rr_q]) begin
            win_vld = 1'b1;
            win     = ~rr_q;
        end
    end

    assign op_bad = (op_q > OP_LAST);

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        data_d    = data_q;
        err_d     = err_q;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    req_ready[win] = 1'b1;
                    owner_d        = win;
                    rr_d           = ~win;
                    op_d           = win ? req_op[2*OPW-1:OPW]  : req_op[OPW-1:0];
                    a_d            = win ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
                    b_d            = win ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];
                    state_d        = ST_EXEC;
                end
            end
            ST_EXEC: begin
                data_d  = op_bad ? '0 : alu_out;
                err_d   = op_bad;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Operand registers only change on accept, so they hold their values outside EXEC.
    assign alu_op       = op_q;
    assign alu_rs1      = a_q;
    assign alu_rs2      = b_q;
    assign alu_imme_sel = 2'b00;

    always_comb begin
        rsp_valid = '0;
        if (state_q == ST_RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    assign rsp_data = data_q;
    assign rsp_err  = err_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU on alu_out.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [3:0]  alu_op;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [1:0]  alu_imme_sel;
    logic [31:0] alu_out;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_share_arbiter #(.XLEN(32), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_imme_sel(alu_imme_sel), .alu_out(alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Garbage for undefined op codes so a response that is not forced to zero shows up.
    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a << b[4:0];
            4'd2: return {31'b0, $signed(a) < $signed(b)};
            4'd3: return {31'b0, a < b};
            4'd4: return a ^ b;
            4'd5: return a >> b[4:0];
            4'd6: return $unsigned($signed(a) >>> b[4:0]);
            4'd7: return a | b;
            4'd8: return a & b;
            4'd9: return a - b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb alu_out = alu_model(alu_op, alu_rs1, alu_rs2);

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (i == 0) begin
            req_op[3:0] = op; req_a[31:0] = a; req_b[31:0] = b;
        end else begin
            req_op[7:4] = op; req_a[63:32] = a; req_b[63:32] = b;
        end
    endtask

    task automatic push_exp(input logic owner, input logic [31:0] data, input logic err);
        exp_t e;
        e.owner = owner; e.data = data; e.err = err;
        sb.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (sb.size() != 0);
        e.owner = 1'b0; e.data = '0; e.err = 1'b0;
        if (ok) e = sb.pop_front();
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_err, busy} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {req_ready, rsp_valid, rsp_err, busy});
        end
        n_cmp++;
        if ({rsp_data, alu_op, alu_rs1, alu_rs2, alu_imme_sel} !== '0) begin
            n_bad++; $display("FAIL reset_data: rsp_data=%h op=%h rs1=%h rs2=%h sel=%b want all 0",
                              rsp_data, alu_op, alu_rs1, alu_rs2, alu_imme_sel);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        exp_t e; bit ok;
        rsp_ready = 2'b11;
        @(posedge clk); #1;
        set_req(0, 4'd0, 32'd5, 32'd7);
        req_valid = 2'b01;
        push_exp(1'b0, 32'd12, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01 || busy !== 1'b0) begin
            n_bad++; $display("FAIL single_accept: req_ready=%b busy=%b want 01 0", req_ready, busy);
        end
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || rsp_valid !== 2'b00 || alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7 || alu_op !== 4'd0) begin
            n_bad++; $display("FAIL single_exec: busy=%b rsp_valid=%b op=%h rs1=%h rs2=%h want 1 00 0 5 7",
                              busy, rsp_valid, alu_op, alu_rs1, alu_rs2);
        end
        @(negedge clk);
        pop_exp(e, ok);
        n_cmp++;
        if (!ok || rsp_valid !== 2'b01 || rsp_data !== e.data || rsp_err !== e.err || busy !== 1'b1) begin
            n_bad++; $display("FAIL single_rsp: valid=%b data=%h err=%b busy=%b want 01 %h %b 1",
                              rsp_valid, rsp_data, rsp_err, busy, e.data, e.err);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            n_bad++; $display("FAIL single_done: busy=%b rsp_valid=%b want 0 00", busy, rsp_valid);
        end
    endtask

    task automatic test_simultaneous();
        exp_t e; bit ok;
        do_reset();
        rsp_ready = 2'b11;
        @(posedge clk); #1;
        set_req(0, 4'd9, 32'd10, 32'd3);
        set_req(1, 4'd4, 32'hF0, 32'h0F);
        req_valid = 2'b11;
        push_exp(1'b0, 32'd7, 1'b0);
        push_exp(1'b1, 32'hFF, 1'b0);
        for (int t = 0; t < 2; t++) begin
            wait_grant(ok);
            n_cmp++;
            if (!ok || req_ready !== (t == 0 ? 2'b01 : 2'b10)) begin
                n_bad++; $display("FAIL simul_grant%0d: req_ready=%b ok=%0d want %b", t, req_ready, ok, (t == 0 ? 2'b01 : 2'b10));
            end
            @(posedge clk); #1 req_valid[t] = 1'b0;
            wait_rsp(ok);
            pop_exp(e, ok);
            n_cmp++;
            if (!ok || rsp_valid !== (2'b01 << e.owner) || rsp_data !== e.data || rsp_err !== e.err) begin
                n_bad++; $display("FAIL simul_rsp%0d: valid=%b data=%h err=%b want %b %h %b",
                                  t, rsp_valid, rsp_data, rsp_err, (2'b01 << e.owner), e.data, e.err);
            end
        end
    endtask

    task automatic test_fairness();
        exp_t e; bit ok; logic w;
        rsp_ready = 2'b11;
        @(posedge clk); #1;
        set_req(0, 4'd0, 32'd100, 32'd1);
        set_req(1, 4'd9, 32'd200, 32'd2);
        req_valid = 2'b11;
        for (int t = 0; t < 6; t++) begin
            wait_grant(ok);
            w = req_ready[1];
            n_cmp++;
            if (!ok || req_ready !== ((t % 2) == 0 ? 2'b01 : 2'b10)) begin
                n_bad++; $display("FAIL fair_grant%0d: req_ready=%b want %b", t, req_ready, ((t % 2) == 0 ? 2'b01 : 2'b10));
            end
            if (w) push_exp(1'b1, alu_model(req_op[7:4], req_a[63:32], req_b[63:32]), 1'b0);
            else   push_exp(1'b0, alu_model(req_op[3:0], req_a[31:0], req_b[31:0]), 1'b0);
            @(posedge clk); #1;
            if (w) set_req(1, 4'(1 + t), $urandom, 32'($urandom_range(0, 40)));
            else   set_req(0, 4'(2 + t), $urandom, 32'($urandom_range(0, 40)));
            wait_rsp(ok);
            pop_exp(e, ok);
            n_cmp++;
            if (!ok || rsp_valid !== (2'b01 << e.owner) || rsp_data !== e.data || rsp_err !== e.err) begin
                n_bad++; $display("FAIL fair_rsp%0d: valid=%b data=%h err=%b want %b %h %b",
                                  t, rsp_valid, rsp_data, rsp_err, (2'b01 << e.owner), e.data, e.err);
            end
        end
        @(posedge clk); #1 req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        exp_t e; bit ok;
        rsp_ready = 2'b01;
        set_req(1, 4'd1, 32'd1, 32'd33);
        set_req(0, 4'd0, 32'd3, 32'd4);
        req_valid = 2'b10;
        push_exp(1'b1, 32'd2, 1'b0);
        push_exp(1'b0, 32'd7, 1'b0);
        wait_grant(ok);
        n_cmp++;
        if (!ok || req_ready !== 2'b10) begin
            n_bad++; $display("FAIL bp_grant: req_ready=%b want 10", req_ready);
        end
        @(posedge clk); #1 req_valid = 2'b01;
        @(negedge clk);
        pop_exp(e, ok);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (!ok || rsp_valid !== 2'b10 || rsp_data !== e.data || rsp_err !== 1'b0 || req_ready !== 2'b00) begin
                n_bad++; $display("FAIL bp_hold%0d: valid=%b data=%h err=%b req_ready=%b want 10 %h 0 00",
                                  c, rsp_valid, rsp_data, rsp_err, req_ready, e.data);
            end
        end
        #1 rsp_ready = 2'b11;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01 || rsp_valid !== 2'b00) begin
            n_bad++; $display("FAIL bp_release: req_ready=%b rsp_valid=%b want 01 00", req_ready, rsp_valid);
        end
        @(posedge clk); #1 req_valid = 2'b00;
        wait_rsp(ok);
        pop_exp(e, ok);
        n_cmp++;
        if (!ok || rsp_valid !== 2'b01 || rsp_data !== e.data) begin
            n_bad++; $display("FAIL bp_next: valid=%b data=%h want 01 %h", rsp_valid, rsp_data, e.data);
        end
    endtask

    task automatic test_err();
        exp_t e; bit ok;
        rsp_ready = 2'b11;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            if (t == 0) begin
                set_req(0, 4'b1100, 32'h1234_5678, 32'h1111_1111);
                req_valid = 2'b01;
                push_exp(1'b0, 32'h0, 1'b1);
            end else begin
                set_req(1, 4'd0, 32'h1234_5678, 32'h1111_1111);
                req_valid = 2'b10;
                push_exp(1'b1, 32'h2345_6789, 1'b0);
            end
            wait_grant(ok);
            @(posedge clk); #1 req_valid = 2'b00;
            wait_rsp(ok);
            pop_exp(e, ok);
            n_cmp++;
            if (!ok || rsp_valid !== (2'b01 << e.owner) || rsp_data !== e.data || rsp_err !== e.err) begin
                n_bad++; $display("FAIL err_case%0d: valid=%b data=%h err=%b want %b %h %b",
                                  t, rsp_valid, rsp_data, rsp_err, (2'b01 << e.owner), e.data, e.err);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e; bit ok; bit seen;
        rsp_ready = 2'b11;
        @(posedge clk); #1;
        set_req(0, 4'd0, 32'd40, 32'd2);
        req_valid = 2'b01;
        wait_grant(ok);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL mid_exec: busy=%b want 1", busy);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, req_ready, busy, rsp_err} !== 6'b0 || {rsp_data, alu_op, alu_rs1, alu_rs2} !== '0) begin
            n_bad++; $display("FAIL mid_reset: valid=%b ready=%b busy=%b err=%b data=%h op=%h rs1=%h rs2=%h want all 0",
                              rsp_valid, req_ready, busy, rsp_err, rsp_data, alu_op, alu_rs1, alu_rs2);
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 2'b00) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++; $display("FAIL mid_norsp: rsp_valid seen after aborted transaction, want none");
        end
        sb.delete();
        @(posedge clk); #1;
        set_req(1, 4'd8, 32'hFFFF_0000, 32'h00FF_00FF);
        req_valid = 2'b10;
        push_exp(1'b1, 32'h00FF_0000, 1'b0);
        wait_grant(ok);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_rsp(ok);
        pop_exp(e, ok);
        n_cmp++;
        if (!ok || rsp_valid !== 2'b10 || rsp_data !== e.data || rsp_err !== e.err) begin
            n_bad++; $display("FAIL mid_after: valid=%b data=%h err=%b want 10 %h %b",
                              rsp_valid, rsp_data, rsp_err, e.data, e.err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_backpressure();
        test_err();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
